// File: rtl/dm_store_buffer.sv
// In-order store write buffer between the MEM-stage store path and data memory.
// Optional load forwarding from fully covering entries when STBUF_FWD_EN is defined.
module dm_store_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [31:0] st_pc,
   input  logic [31:0] st_addr,
   input  logic [1:0]  st_size,
   input  logic [31:0] st_data,
   output logic        dm_we,
   input  logic        dm_ready,
   output logic [31:0] dm_pc,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wd,
   input  logic        ld_valid,
   input  logic [31:0] ld_addr,
   input  logic [1:0]  ld_size,
   output logic        ld_stall,
   output logic        ld_fwd,
   output logic [31:0] ld_fwd_data,
   output logic        empty
);

   localparam int unsigned CNT_W = PTR_W + 1;

   function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         2'b00:   be = 4'b1111;
         2'b01:   be = 4'b0001 << lo;
         2'b10:   be = lo[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
      logic [31:0] r;
      r = d;
      case (size)
         2'b01:   r = {4{d[7:0]}};
         2'b10:   r = {2{d[15:0]}};
         default: r = d;
      endcase
      return r;
   endfunction

   logic             valid_q [DEPTH];
   logic             valid_d [DEPTH];
   logic [31:0]      pc_q    [DEPTH];
   logic [31:0]      pc_d    [DEPTH];
   logic [29:0]      waddr_q [DEPTH];
   logic [29:0]      waddr_d [DEPTH];
   logic [3:0]       be_q    [DEPTH];
   logic [3:0]       be_d    [DEPTH];
   logic [31:0]      data_q  [DEPTH];
   logic [31:0]      data_d  [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic       push_c;
   logic       pop_c;
   logic [3:0] ld_be_c;
   logic       overlap_c;

   assign st_ready = (count_q != CNT_W'(DEPTH));
   assign push_c   = st_valid && st_ready && (st_size != 2'b11);
   assign dm_we    = (count_q != '0);
   assign pop_c    = dm_we && dm_ready;
   assign empty    = (count_q == '0);

   // Head entry presented to memory; zeroed when nothing is pending.
   assign dm_pc   = dm_we ? pc_q[rd_ptr_q] : 32'h0;
   assign dm_addr = dm_we ? {waddr_q[rd_ptr_q], 2'b00} : 32'h0;
   assign dm_be   = dm_we ? be_q[rd_ptr_q] : 4'b0000;
   assign dm_wd   = dm_we ? data_q[rd_ptr_q] : 32'h0;

   always_comb begin
      valid_d  = valid_q;
      pc_d     = pc_q;
      waddr_d  = waddr_q;
      be_d     = be_q;
      data_d   = data_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_c) begin
         valid_d[wr_ptr_q] = 1'b1;
         pc_d[wr_ptr_q]    = st_pc;
         waddr_d[wr_ptr_q] = st_addr[31:2];
         be_d[wr_ptr_q]    = lane_be(st_size, st_addr[1:0]);
         data_d[wr_ptr_q]  = lane_data(st_size, st_data);
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            pc_q[i]    <= 32'h0;
            waddr_q[i] <= 30'h0;
            be_q[i]    <= 4'b0000;
            data_q[i]  <= 32'h0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         pc_q     <= pc_d;
         waddr_q  <= waddr_d;
         be_q     <= be_d;
         data_q   <= data_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Any pending entry sharing a byte with the load blocks it (pre-edge state).
   always_comb begin
      ld_be_c   = lane_be(ld_size, ld_addr[1:0]);
      overlap_c = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (waddr_q[i] == ld_addr[31:2]) && ((be_q[i] & ld_be_c) != 4'b0000))
            overlap_c = 1'b1;
      end
   end

`ifdef STBUF_FWD_EN
   logic [PTR_W-1:0] idx_c;
   logic             hit_c;
   logic [3:0]       hit_be_c;
   logic [31:0]      hit_data_c;
   logic             covered_c;

   // Walk oldest to youngest so the last match is the youngest overlapping entry.
   always_comb begin
      idx_c      = rd_ptr_q;
      hit_c      = 1'b0;
      hit_be_c   = 4'b0000;
      hit_data_c = 32'h0;
      for (int k = 0; k < DEPTH; k++) begin
         idx_c = rd_ptr_q + PTR_W'(k);
         if (valid_q[idx_c] && (waddr_q[idx_c] == ld_addr[31:2]) &&
             ((be_q[idx_c] & ld_be_c) != 4'b0000)) begin
            hit_c      = 1'b1;
            hit_be_c   = be_q[idx_c];
            hit_data_c = data_q[idx_c];
         end
      end
      covered_c = hit_c && ((hit_be_c & ld_be_c) == ld_be_c);
   end

   assign ld_fwd      = ld_valid && covered_c;
   assign ld_fwd_data = ld_fwd ? hit_data_c : 32'h0;
   assign ld_stall    = ld_valid && overlap_c && !covered_c;
`else
   assign ld_fwd      = 1'b0;
   assign ld_fwd_data = 32'h0;
   assign ld_stall    = ld_valid && overlap_c;
`endif

endmodule

// File: tb/tb_dm_store_buffer.sv
// Directed self-checking bench for dm_store_buffer (both STBUF_FWD_EN builds).
`timescale 1ns/1ps
module tb_dm_store_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_pc;
   logic [31:0] st_addr;
   logic [1:0]  st_size;
   logic [31:0] st_data;
   logic        dm_we;
   logic        dm_ready;
   logic [31:0] dm_pc;
   logic [31:0] dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_wd;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic [1:0]  ld_size;
   logic        ld_stall;
   logic        ld_fwd;
   logic [31:0] ld_fwd_data;
   logic        empty;

   int total = 0;
   int bad   = 0;
   int seen_we;

   always #5 clk = ~clk;

   dm_store_buffer dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_ready(st_ready), .st_pc(st_pc), .st_addr(st_addr),
      .st_size(st_size), .st_data(st_data),
      .dm_we(dm_we), .dm_ready(dm_ready), .dm_pc(dm_pc), .dm_addr(dm_addr),
      .dm_be(dm_be), .dm_wd(dm_wd),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
      .ld_stall(ld_stall), .ld_fwd(ld_fwd), .ld_fwd_data(ld_fwd_data),
      .empty(empty)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] a,
                       input logic [1:0] sz, input logic [31:0] d);
      st_valid = 1'b1;
      st_pc    = pc;
      st_addr  = a;
      st_size  = sz;
      st_data  = d;
      tick();
      st_valid = 1'b0;
   endtask

   task automatic load(input logic [31:0] a, input logic [1:0] sz);
      ld_valid = 1'b1;
      ld_addr  = a;
      ld_size  = sz;
      #1;
   endtask

   initial begin
      reset = 1'b1; st_valid = 1'b0; st_pc = '0; st_addr = '0; st_size = '0; st_data = '0;
      dm_ready = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_size = '0;
      tick(); tick();
      chk("rst_st_ready", 32'(st_ready), 32'd1);
      chk("rst_dm_we", 32'(dm_we), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_dm_be", 32'(dm_be), 32'd0);
      chk("rst_dm_wd", dm_wd, 32'h0);
      chk("rst_ld_fwd", 32'(ld_fwd), 32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_empty", 32'(empty), 32'd1);

      // word store, immediate drain
      dm_ready = 1'b1;
      push(32'h3000, 32'h10, 2'b00, 32'hDEADBEEF);
      chk("w_we", 32'(dm_we), 32'd1);
      chk("w_addr", dm_addr, 32'h10);
      chk("w_be", 32'(dm_be), 32'hF);
      chk("w_wd", dm_wd, 32'hDEADBEEF);
      chk("w_pc", dm_pc, 32'h3000);
      tick();
      chk("w_empty", 32'(empty), 32'd1);
      chk("w_we_off", 32'(dm_we), 32'd0);

      // byte and half alignment
      push(32'h3004, 32'h13, 2'b01, 32'h000000A5);
      chk("b_be", 32'(dm_be), 32'h8);
      chk("b_wd", dm_wd, 32'hA5A5A5A5);
      chk("b_addr", dm_addr, 32'h10);
      tick();
      push(32'h3008, 32'h22, 2'b10, 32'h00001234);
      chk("h_be", 32'(dm_be), 32'hC);
      chk("h_wd", dm_wd, 32'h12341234);
      chk("h_addr", dm_addr, 32'h20);
      tick();
      // reserved size is dropped
      push(32'h300C, 32'h30, 2'b11, 32'h1);
      chk("rsv_empty", 32'(empty), 32'd1);

      // fill to full with memory stalled
      dm_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         push(32'h100 + 32'(i), 32'h100 + 32'(4 * i), 2'b00, 32'(i + 1));
      chk("full_ready", 32'(st_ready), 32'd0);
      chk("full_head", dm_wd, 32'd1);
      push(32'h1FF, 32'h200, 2'b00, 32'h55);
      chk("full_ready2", 32'(st_ready), 32'd0);
      dm_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_wd", dm_wd, 32'(i + 1));
         chk("drain_addr", dm_addr, 32'h100 + 32'(4 * i));
         chk("drain_pc", dm_pc, 32'h100 + 32'(i));
         tick();
         if (i == 0) chk("drain_ready", 32'(st_ready), 32'd1);
      end
      chk("drain_empty", 32'(empty), 32'd1);

      // overlap detection
      dm_ready = 1'b0;
      push(32'h400, 32'h41, 2'b01, 32'h77);
      load(32'h40, 2'b00);
      chk("ovl_word", 32'(ld_stall), 32'd1);
      load(32'h42, 2'b01);
      chk("ovl_byte_other", 32'(ld_stall), 32'd0);
      load(32'h40, 2'b10);
      chk("ovl_half", 32'(ld_stall), 32'd1);
      load(32'h44, 2'b00);
      chk("ovl_other_word", 32'(ld_stall), 32'd0);
      load(32'h41, 2'b01);
`ifdef STBUF_FWD_EN
      chk("ovl_exact_stall", 32'(ld_stall), 32'd0);
      chk("ovl_exact_fwd", 32'(ld_fwd), 32'd1);
      chk("ovl_exact_data", ld_fwd_data, 32'h77777777);
`else
      chk("ovl_exact_stall", 32'(ld_stall), 32'd1);
      chk("ovl_exact_fwd", 32'(ld_fwd), 32'd0);
`endif
      load(32'h40, 2'b00);
      dm_ready = 1'b1;
      #1;
      chk("ovl_prepop", 32'(ld_stall), 32'd1);
      tick();
      chk("ovl_after", 32'(ld_stall), 32'd0);
      ld_valid = 1'b0;
      #1;
      chk("ovl_novalid", 32'(ld_stall), 32'd0);

      // youngest-entry forwarding
      dm_ready = 1'b0;
      push(32'h500, 32'h50, 2'b00, 32'h11111111);
      push(32'h504, 32'h50, 2'b00, 32'h22222222);
      load(32'h52, 2'b01);
`ifdef STBUF_FWD_EN
      chk("fwd_flag", 32'(ld_fwd), 32'd1);
      chk("fwd_data", ld_fwd_data, 32'h22222222);
      chk("fwd_stall", 32'(ld_stall), 32'd0);
`else
      chk("fwd_flag", 32'(ld_fwd), 32'd0);
      chk("fwd_data", ld_fwd_data, 32'h0);
      chk("fwd_stall", 32'(ld_stall), 32'd1);
`endif
      ld_valid = 1'b0;
      dm_ready = 1'b1;
      tick(); tick();
      chk("fwd_drained", 32'(empty), 32'd1);
      dm_ready = 1'b0;
      push(32'h508, 32'h50, 2'b01, 32'h99);
      load(32'h50, 2'b10);
      chk("part_stall", 32'(ld_stall), 32'd1);
      chk("part_fwd", 32'(ld_fwd), 32'd0);
      ld_valid = 1'b0;
      dm_ready = 1'b1;
      tick();

      // asynchronous reset mid-drain
      dm_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         push(32'h600 + 32'(i), 32'h600 + 32'(4 * i), 2'b00, 32'hA0 + 32'(i));
      dm_ready = 1'b1;
      #1;
      chk("ar_we_before", 32'(dm_we), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("ar_we_async", 32'(dm_we), 32'd0);
      chk("ar_empty_async", 32'(empty), 32'd1);
      chk("ar_ready_async", 32'(st_ready), 32'd1);
      tick(); tick();
      reset = 1'b0;
      seen_we = 0;
      for (int i = 0; i < 5; i++) begin
         if (dm_we) seen_we++;
         tick();
      end
      chk("ar_no_writes", 32'(seen_we), 32'd0);
      chk("ar_empty", 32'(empty), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
